trade_report_packer: RTL and testbench

Transmit-side framer for the matching engine's 32-bit trade/dump report stream (`trade_valid`/`trade_info`). It buffers report words in an internal FIFO and emits them as framed byte packets on a valid/ready byte stream toward the UDP transmit path. Words are treated as opaque 32-bit values and sent unmodified.

---
 rtl/trade_report_packer.sv | 190 +++++++++++++++++++
 tb/tb_trade_report_packer.sv | 315 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/trade_report_packer.sv
`timescale 1ns/1ps
// Frames 32-bit trade/dump report words into A5/seq/N byte packets on a
// valid/ready byte stream, buffering words in an internal FIFO.
module trade_report_packer #(
  parameter int unsigned FIFO_DEPTH   = 64,
  parameter int unsigned MAX_WORDS    = 16,
  parameter int unsigned IDLE_TIMEOUT = 256
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          trade_valid,
  input  logic [31:0]                   trade_info,
  input  logic                          flush,
  output logic [7:0]                    m_tdata,
  output logic                          m_tvalid,
  input  logic                          m_tready,
  output logic                          m_tlast,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
  output logic [15:0]                   overflow_cnt
);

  localparam int unsigned AW = $clog2(FIFO_DEPTH);
  localparam int unsigned LW = AW + 1;
  localparam int unsigned TW = $clog2(IDLE_TIMEOUT + 1);
  localparam logic [7:0]  SYNC_BYTE = 8'hA5;

  typedef enum logic [1:0] {IDLE, HDR, DATA} state_t;

  state_t        state, state_d;
  logic [31:0]   mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [7:0]    seq, seq_d;
  logic [7:0]    n_words, n_words_d;
  logic [7:0]    word_cnt, word_cnt_d;
  logic [1:0]    idx, idx_d;
  logic [TW-1:0] idle_cnt, idle_cnt_d;
  logic          flush_pend, flush_pend_d;
  logic [7:0]    tdata_d;
  logic          tvalid_d, tlast_d;
  logic          push, pop, start;
  logic [31:0]   head;
  logic [7:0]    next_msb;

  function automatic logic [7:0] word_byte(input logic [31:0] w, input logic [1:0] i);
    return w[{i, 3'b000} +: 8];
  endfunction

  // Fullness uses the start-of-cycle level, so a same-cycle pop never rescues a push.
  assign push     = trade_valid && (fifo_level < LW'(FIFO_DEPTH));
  assign pop      = (state == DATA) && m_tready && (idx == 2'd0);
  assign head     = mem[rd_ptr];
  assign next_msb = mem[rd_ptr + AW'(1)][31:24];
  assign start    = (state == IDLE) &&
                    ((fifo_level >= LW'(MAX_WORDS)) ||
                     (flush_pend && (fifo_level != '0)) ||
                     (idle_cnt >= TW'(IDLE_TIMEOUT)));

  // Next-state and next-output logic; outputs hold unless a byte is accepted.
  always_comb begin
    state_d      = state;
    idx_d        = idx;
    seq_d        = seq;
    n_words_d    = n_words;
    word_cnt_d   = word_cnt;
    tdata_d      = m_tdata;
    tvalid_d     = m_tvalid;
    tlast_d      = m_tlast;
    idle_cnt_d   = idle_cnt;
    flush_pend_d = flush_pend;

    if (push || start) begin
      idle_cnt_d = '0;
    end else if ((state == IDLE) && (fifo_level != '0) && (idle_cnt < TW'(IDLE_TIMEOUT))) begin
      idle_cnt_d = idle_cnt + TW'(1);
    end

    if (flush) begin
      flush_pend_d = 1'b1;
    end else if (start || ((state == IDLE) && (fifo_level == '0))) begin
      flush_pend_d = 1'b0;
    end

    case (state)
      IDLE: begin
        if (start) begin
          state_d    = HDR;
          idx_d      = 2'd0;
          word_cnt_d = 8'd0;
          n_words_d  = (fifo_level >= LW'(MAX_WORDS)) ? 8'(MAX_WORDS) : 8'(fifo_level);
          tdata_d    = SYNC_BYTE;
          tvalid_d   = 1'b1;
          tlast_d    = 1'b0;
        end
      end
      HDR: begin
        if (m_tready) begin
          case (idx)
            2'd0: begin
              tdata_d = seq;
              idx_d   = 2'd1;
            end
            2'd1: begin
              tdata_d = n_words;
              idx_d   = 2'd2;
            end
            default: begin
              state_d = DATA;
              idx_d   = 2'd3;
              tdata_d = head[31:24];
            end
          endcase
        end
      end
      DATA: begin
        if (m_tready) begin
          if (idx != 2'd0) begin
            idx_d   = idx - 2'd1;
            tdata_d = word_byte(head, idx - 2'd1);
            tlast_d = (idx == 2'd1) && (word_cnt == n_words - 8'd1);
          end else if (word_cnt == n_words - 8'd1) begin
            state_d  = IDLE;
            tvalid_d = 1'b0;
            tlast_d  = 1'b0;
            tdata_d  = 8'd0;
            seq_d    = seq + 8'd1;
          end else begin
            word_cnt_d = word_cnt + 8'd1;
            idx_d      = 2'd3;
            tdata_d    = next_msb;
            tlast_d    = 1'b0;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // FSM and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      idx        <= 2'd0;
      seq        <= 8'd0;
      n_words    <= 8'd0;
      word_cnt   <= 8'd0;
      idle_cnt   <= '0;
      flush_pend <= 1'b0;
      m_tdata    <= 8'd0;
      m_tvalid   <= 1'b0;
      m_tlast    <= 1'b0;
    end else begin
      state      <= state_d;
      idx        <= idx_d;
      seq        <= seq_d;
      n_words    <= n_words_d;
      word_cnt   <= word_cnt_d;
      idle_cnt   <= idle_cnt_d;
      flush_pend <= flush_pend_d;
      m_tdata    <= tdata_d;
      m_tvalid   <= tvalid_d;
      m_tlast    <= tlast_d;
    end
  end

  // FIFO pointers, occupancy and drop counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      fifo_level   <= '0;
      overflow_cnt <= 16'd0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({push, pop})
        2'b10:   fifo_level <= fifo_level + LW'(1);
        2'b01:   fifo_level <= fifo_level - LW'(1);
        default: fifo_level <= fifo_level;
      endcase
      if (trade_valid && !push && (overflow_cnt != 16'hFFFF)) begin
        overflow_cnt <= overflow_cnt + 16'd1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= trade_info;
  end

endmodule

// File: tb/tb_trade_report_packer.sv
`timescale 1ns/1ps
// Directed bench for trade_report_packer: a packet-level scoreboard checks every
// accepted byte and the stream rules, plus literal checks on chosen packets.
module tb_trade_report_packer;

  logic        clk;
  logic        rst_n;
  logic        trade_valid;
  logic [31:0] trade_info;
  logic        flush;
  logic [7:0]  m_tdata;
  logic        m_tvalid;
  logic        m_tready;
  logic        m_tlast;
  logic [6:0]  fifo_level;
  logic [15:0] overflow_cnt;

  trade_report_packer #(.FIFO_DEPTH(64), .MAX_WORDS(16), .IDLE_TIMEOUT(8)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .trade_valid  (trade_valid),
    .trade_info   (trade_info),
    .flush        (flush),
    .m_tdata      (m_tdata),
    .m_tvalid     (m_tvalid),
    .m_tready     (m_tready),
    .m_tlast      (m_tlast),
    .fifo_level   (fifo_level),
    .overflow_cnt (overflow_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: actual=0x%0h required=0x%0h at t=%0t", nm, act, exp, $time);
    end
  endtask

  // Model state: words the design must emit in order, and expected packet sizes.
  logic [31:0] words_q[$];
  int          exp_n[$];
  logic [7:0]  exp_bytes[$];
  logic [7:0]  mseq;
  bit          in_pkt, gap_due;
  logic [7:0]  cap [0:127];
  logic [7:0]  last_pkt [0:127];
  int          cap_len, last_len, pkt_done, stall_cnt;
  logic        prev_valid, prev_ready, prev_last;
  logic [7:0]  prev_data;
  logic [7:0]  eb;
  logic [31:0] mw;
  int          mn;

  // Ready driver: held level or pseudo-random toggling.
  bit ready_mode;
  logic ready_level;
  initial begin
    m_tready = 1'b1;
    forever begin
      @(posedge clk); #1;
      m_tready = ready_mode ? 1'($urandom_range(0, 1)) : ready_level;
    end
  end

  // Scoreboard: one sample per cycle, away from the active edge.
  initial begin
    pkt_done = 0; stall_cnt = 0; last_len = 0; cap_len = 0;
    in_pkt = 0; gap_due = 0; mseq = 8'd0;
    prev_valid = 0; prev_ready = 0; prev_last = 0; prev_data = 8'd0;
  end

  always @(negedge clk) begin
    if (!rst_n) begin
      exp_bytes.delete();
      mseq = 8'd0; in_pkt = 0; gap_due = 0; cap_len = 0;
      prev_valid = 0; prev_ready = 0; prev_last = 0; prev_data = 8'd0;
    end else begin
      if (prev_valid && !prev_ready) begin
        stall_cnt++;
        chk("stall_hold", {22'd0, m_tvalid, m_tlast, m_tdata}, {22'd0, 1'b1, prev_last, prev_data});
      end
      if (gap_due) begin
        chk("idle_gap", {31'd0, m_tvalid}, 32'd0);
        gap_due = 0;
      end else if (in_pkt) begin
        chk("valid_mid_pkt", {31'd0, m_tvalid}, 32'd1);
      end
      if (m_tvalid && m_tready) begin
        if (!in_pkt) begin
          if (exp_n.size() == 0) begin
            chk("unexpected_pkt_byte", {24'd0, m_tdata}, 32'hFFFF_FFFF);
          end else begin
            mn = exp_n.pop_front();
            exp_bytes.delete();
            exp_bytes.push_back(8'hA5);
            exp_bytes.push_back(mseq);
            exp_bytes.push_back(8'(mn));
            for (int i = 0; i < mn; i++) begin
              if (words_q.size() == 0) begin
                chk("model_words_short", 32'd0, 32'd1);
                mw = 32'd0;
              end else begin
                mw = words_q.pop_front();
              end
              exp_bytes.push_back(mw[31:24]);
              exp_bytes.push_back(mw[23:16]);
              exp_bytes.push_back(mw[15:8]);
              exp_bytes.push_back(mw[7:0]);
            end
            in_pkt = 1;
            cap_len = 0;
          end
        end
        if (in_pkt) begin
          eb = exp_bytes.pop_front();
          chk("byte", {24'd0, m_tdata}, {24'd0, eb});
          chk("tlast", {31'd0, m_tlast}, {31'd0, exp_bytes.size() == 0});
          cap[cap_len] = m_tdata;
          cap_len++;
          if (exp_bytes.size() == 0) begin
            in_pkt = 0; gap_due = 1; mseq = mseq + 8'd1;
            last_pkt = cap; last_len = cap_len; pkt_done++;
          end
        end
      end
      prev_valid = m_tvalid; prev_ready = m_tready;
      prev_last = m_tlast; prev_data = m_tdata;
    end
  end

  task automatic push_word(input logic [31:0] w, input bit acc);
    trade_valid = 1'b1;
    trade_info  = w;
    if (acc) words_q.push_back(w);
    @(posedge clk); #1;
    trade_valid = 1'b0;
  endtask

  task automatic pulse_flush();
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
  endtask

  task automatic wait_pkts(input int target, input int budget);
    int c = 0;
    while (pkt_done < target && c < budget) begin
      @(posedge clk); #1;
      c++;
    end
    chk("pkt_wait_budget", {31'd0, pkt_done >= target}, 32'd1);
  endtask

  int base;
  int lat;
  logic [7:0] exp7 [7];

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, checks=%0d", checks);
    $fatal(1, "watchdog");
  end

  initial begin
    trade_valid = 1'b0; trade_info = 32'd0; flush = 1'b0;
    ready_mode = 0; ready_level = 1'b1;
    rst_n = 1'b1;
    #1 rst_n = 1'b0;
    #3;
    chk("rst_tvalid", {31'd0, m_tvalid}, 32'd0);
    chk("rst_tlast", {31'd0, m_tlast}, 32'd0);
    chk("rst_tdata", {24'd0, m_tdata}, 32'd0);
    chk("rst_level", {25'd0, fifo_level}, 32'd0);
    chk("rst_ovf", {16'd0, overflow_cnt}, 32'd0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk); #1;

    // Full 16-word packet.
    base = pkt_done;
    exp_n.push_back(16);
    for (int i = 1; i <= 16; i++) push_word(32'(i), 1'b1);
    wait_pkts(base + 1, 200);
    chk("full_len", 32'(last_len), 32'd67);
    chk("full_b0", {24'd0, last_pkt[0]}, 32'hA5);
    chk("full_seq", {24'd0, last_pkt[1]}, 32'h00);
    chk("full_n", {24'd0, last_pkt[2]}, 32'h10);
    chk("full_b65", {24'd0, last_pkt[65]}, 32'h00);
    chk("full_b66", {24'd0, last_pkt[66]}, 32'h10);

    // Flush of a 3-word partial packet.
    base = pkt_done;
    exp_n.push_back(3);
    push_word(32'h1111_1111, 1'b1);
    push_word(32'h2222_2222, 1'b1);
    push_word(32'h3333_3333, 1'b1);
    @(posedge clk); #1;
    pulse_flush();
    wait_pkts(base + 1, 100);
    chk("flush_len", 32'(last_len), 32'd15);
    chk("flush_seq", {24'd0, last_pkt[1]}, 32'h01);
    chk("flush_n", {24'd0, last_pkt[2]}, 32'h03);

    // Flush with nothing buffered sends nothing.
    base = pkt_done;
    pulse_flush();
    repeat (20) @(posedge clk);
    #1;
    chk("empty_flush_pkts", 32'(pkt_done), 32'(base));
    chk("empty_flush_valid", {31'd0, m_tvalid}, 32'd0);

    // Idle timeout with a single word.
    base = pkt_done;
    exp_n.push_back(1);
    trade_valid = 1'b1; trade_info = 32'hDEAD_BEEF;
    words_q.push_back(32'hDEAD_BEEF);
    @(posedge clk); #1;
    trade_valid = 1'b0;
    lat = 0;
    while (!m_tvalid && lat < 50) begin
      @(posedge clk); #1;
      lat++;
    end
    chk("timeout_latency", 32'(lat), 32'd9);
    wait_pkts(base + 1, 50);
    exp7 = '{8'hA5, 8'h02, 8'h01, 8'hDE, 8'hAD, 8'hBE, 8'hEF};
    chk("timeout_len", 32'(last_len), 32'd7);
    for (int i = 0; i < 7; i++) chk("timeout_byte", {24'd0, last_pkt[i]}, {24'd0, exp7[i]});

    // Random backpressure across a 5-word packet.
    base = pkt_done;
    exp_n.push_back(5);
    ready_mode = 1;
    for (int i = 1; i <= 5; i++) push_word(32'hB0B0_0000 + 32'(i * 16'h1357), 1'b1);
    pulse_flush();
    wait_pkts(base + 1, 400);
    ready_mode = 0; ready_level = 1'b1;
    chk("bp_len", 32'(last_len), 32'd23);
    chk("bp_seq", {24'd0, last_pkt[1]}, 32'h03);
    chk("bp_stalls_seen", {31'd0, stall_cnt > 0}, 32'd1);

    // Overflow with the stream stalled, then drain in four packets.
    ready_level = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    base = pkt_done;
    repeat (4) exp_n.push_back(16);
    for (int i = 1; i <= 70; i++) push_word(32'(i), i <= 64);
    chk("ovf_level", {25'd0, fifo_level}, 32'd64);
    chk("ovf_cnt", {16'd0, overflow_cnt}, 32'd6);
    chk("ovf_stall_valid", {31'd0, m_tvalid}, 32'd1);
    chk("ovf_stall_b0", {24'd0, m_tdata}, 32'hA5);
    ready_level = 1'b1;
    wait_pkts(base + 4, 600);
    chk("ovf_drain_level", {25'd0, fifo_level}, 32'd0);
    chk("ovf_last_seq", {24'd0, last_pkt[1]}, 32'h07);
    chk("ovf_last_word", {24'd0, last_pkt[66]}, 32'h40);
    chk("ovf_cnt_kept", {16'd0, overflow_cnt}, 32'd6);

    // Sequence wrap with 1-word flush packets (seq 8..255, 0, 1).
    for (int i = 0; i < 250; i++) begin
      base = pkt_done;
      exp_n.push_back(1);
      push_word(32'h1000_0000 + 32'(i), 1'b1);
      pulse_flush();
      wait_pkts(base + 1, 60);
      if (i == 247) chk("wrap_seq255", {24'd0, last_pkt[1]}, 32'hFF);
      if (i == 248) chk("wrap_seq0", {24'd0, last_pkt[1]}, 32'h00);
    end
    chk("wrap_seq_after", {24'd0, last_pkt[1]}, 32'h01);

    // Reset in the middle of a packet's data phase.
    exp_n.push_back(16);
    for (int i = 1; i <= 16; i++) push_word(32'hA000_0000 + 32'(i), 1'b1);
    lat = 0;
    while (cap_len < 6 && lat < 100) begin
      @(posedge clk); #1;
      lat++;
    end
    chk("rst_reached_data", {31'd0, cap_len >= 6}, 32'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("midrst_tvalid", {31'd0, m_tvalid}, 32'd0);
    chk("midrst_tlast", {31'd0, m_tlast}, 32'd0);
    chk("midrst_tdata", {24'd0, m_tdata}, 32'd0);
    chk("midrst_level", {25'd0, fifo_level}, 32'd0);
    chk("midrst_ovf", {16'd0, overflow_cnt}, 32'd0);
    words_q.delete();
    exp_n.delete();
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk); #1;
    base = pkt_done;
    exp_n.push_back(1);
    push_word(32'hCAFE_F00D, 1'b1);
    pulse_flush();
    wait_pkts(base + 1, 60);
    chk("post_rst_len", 32'(last_len), 32'd7);
    chk("post_rst_seq", {24'd0, last_pkt[1]}, 32'h00);
    chk("post_rst_b3", {24'd0, last_pkt[3]}, 32'hCA);
    chk("post_rst_b6", {24'd0, last_pkt[6]}, 32'h0D);

    repeat (5) @(posedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
